load_line_merger: RTL and testbench
===================================

Name: load_line_merger

Overview:
- Sits directly downstream of the 128-bit byte rotator in the unaligned-load path.
- Consumes 16-byte lines that have already been rotated by the transfer's start byte offset.
- Stitches each pair of consecutive rotated lines into one aligned 16-byte output word.
- Emits a valid/ready stream of aligned words with a last flag, one transfer at a time.

Parameters:
LEN_W, 8, width of the transfer length in output words (max 2^LEN_W-1 words)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  transfer request pulse, sampled in IDLE only
start_off  input  4  byte offset of first stream byte within first line (0..15)
start_len  input  LEN_W  number of aligned output words; 0 = request ignored
busy  output  1  high while a transfer is in progress
in_valid  input  1  rotated line available
in_ready  output  1  block accepts rotated line
in_data  input  128  rotated line; byte b = original line byte (b+off)%16
out_valid  output  1  aligned word available
out_ready  input  1  consumer accepts word
out_data  output  128  aligned word; byte k = stream byte 16n+k
out_last  output  1  qualifies final word of transfer

Behaviour:
- Reset is asynchronous and active-low, applied at any time including mid-transfer. It clears state to IDLE and sets busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0. It also clears the hold register, offset register and counters. Any partial transfer is discarded.
- Line count per transfer: LINES = start_len when off==0, else start_len+1.
- States:
  - IDLE: start=1 with start_len!=0 latches off and len, sets busy next cycle, and moves to PRIME if off!=0 or STREAM if off==0. Start with len==0 is ignored. Start in any other state is ignored.
  - PRIME: in_ready=1. A handshake loads the hold register H with in_data, produces no output and moves to STREAM.
  - STREAM: in_ready = (!out_valid | out_ready) & words_left!=0. On an input handshake:
    - out_data <= merge(H,in_data); out_valid <= 1; H <= in_data; words_left decrements.
    - out_last <= 1 when words_left==1.
- merge(H,L):
  - off==0: result = L.
  - off!=0: byte b = H byte b for b < 16-off, else L byte b.
- Output register is single entry. out_valid drops on an out_ready handshake unless refilled in the same cycle. Sustained throughput is 1 word/cycle when in_valid=1 and out_ready=1.
- Latency: out_valid rises 1 cycle after the input handshake that completes a word.
- out_data and out_last hold stable while out_valid=1 and out_ready=0. in_ready is low in that condition.
- Completion: the handshake of the word with out_last=1 returns the block to IDLE. busy=0 and in_ready=0 from the next cycle. A new start is accepted in that next cycle.
- No line beyond LINES is accepted. in_ready stays 0 after the last line until the next transfer.
- in_data is don't-care when in_valid=0. out_data retains its last value when out_valid=0.

Optional Feature:
- Macro: LOAD_LINE_MERGER_STATS_EN.
- With it defined, add output stall_cnt (16 bits). It counts cycles with out_valid=1 & out_ready=0, saturates at 16'hFFFF, and clears on reset and on each accepted start.
- Without it, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- off=0, len=2, lines A,B back-to-back, out_ready=1 -> out words A then B; out_last only on B; 2 lines consumed; busy low 1 cycle after B handshake.
- off=3, len=1, rotated lines L0,L1 -> out bytes 0..12 = L0 bytes 0..12, bytes 13..15 = L1 bytes 13..15; out_last=1; exactly 2 lines consumed; in_ready=0 afterwards.
- off=15, len=3, out_ready held low 4 cycles after first word -> out_data/out_last stable, in_ready=0 during stall; all 3 words then correct; 4 lines total. With stats macro defined, stall_cnt=4.
- start pulsed with len=0, and again while busy mid-transfer -> both ignored; running transfer unaffected.
- rst_n asserted asynchronously mid-STREAM (off=5, len=4, after word 1) -> all outputs 0 immediately; a new transfer with off=0, len=1 then completes correctly.
- Back-to-back transfers: second start issued the cycle after the first last-handshake -> accepted; no lines from the first transfer leak into the second.

Source files
------------

// File: rtl/load_line_merger.sv
// Unaligned-load line merger: stitches consecutive byte-rotated 16-byte lines into aligned
// 16-byte words. Optional stall counter is enabled with `define LOAD_LINE_MERGER_STATS_EN.
module load_line_merger #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       start_off,
    input  logic [LEN_W-1:0] start_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic [1:0]       dbg_state
`ifdef LOAD_LINE_MERGER_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready; a source
    // holds data stable while valid=1 and ready=0, and ready never depends on valid.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       off_q;
    logic [LEN_W-1:0] words_left;
    logic [127:0]     hold_q;
    logic [127:0]     out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             start_acc;
    logic             in_hs;
    logic             out_hs;
    logic [127:0]     low_mask;
    logic [127:0]     merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (start_len != '0)) begin
                    start_acc = 1'b1;
                    state_nxt = (start_off != 4'd0) ? S_PRIME : S_STREAM;
                end
            end
            S_PRIME: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                in_ready = (!out_valid_q || out_ready) && (words_left != '0);
                if (out_valid_q && out_ready && out_last_q) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    // The low 16-off bytes come from the held line, the rest from the newly arrived line.
    assign low_mask = {128{1'b1}} >> {off_q, 3'b000};
    assign merged   = (off_q == 4'd0) ? in_data : ((hold_q & low_mask) | (in_data & ~low_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= 4'd0;
            words_left  <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                off_q      <= start_off;
                words_left <= start_len;
            end
            if (in_hs && (state == S_PRIME)) begin
                hold_q <= in_data;
            end else if (in_hs && (state == S_STREAM)) begin
                hold_q      <= in_data;
                out_data_q  <= merged;
                out_valid_q <= 1'b1;
                out_last_q  <= (words_left == LEN_W'(1));
                words_left  <= words_left - LEN_W'(1);
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

`ifdef LOAD_LINE_MERGER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                   stall_cnt <= 16'd0;
        else if (start_acc)                                           stall_cnt <= 16'd0;
        else if (out_valid_q && !out_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign busy      = (state != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_load_line_merger.sv
// Self-checking bench for load_line_merger: directed and random transfers checked against
// a byte-stream reference model (aligned word n, byte k = stream byte 16n+k).
module tb_load_line_merger;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       start_off;
    logic [LEN_W-1:0] start_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;
    logic [1:0]       dbg_state;
`ifdef LOAD_LINE_MERGER_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    load_line_merger #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_off (start_off),
        .start_len (start_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .dbg_state (dbg_state)
`ifdef LOAD_LINE_MERGER_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      128'(busy),      128'(0));
        check({tag, "_in_ready"},  128'(in_ready),  128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_last"},  128'(out_last),  128'(0));
        check({tag, "_out_data"},  out_data,        128'(0));
`ifdef LOAD_LINE_MERGER_STATS_EN
        check({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(0));
`endif
    endtask

    // driver + monitor for one transfer.
    // rdy_mode: 0 out_ready=1, 1 random, 2 held low 4 cycles once the first word appears.
    // abort_after: return after this many output handshakes (0 = run to completion).
    task automatic run_xfer(input int off, input int len, input int rdy_mode,
                            input bit rnd_valid, input bit poke_start, input int abort_after);
        logic [7:0]   ob[$];
        logic [127:0] rot[$];
        logic [127:0] line;
        logic [127:0] held_data;
        logic         held_last;
        logic         prev_stall;
        logic         hs_in, hs_out;
        int nlines, li, got, cyc, stall_left;
        bit stall_used, done;

        nlines = (off == 0) ? len : len + 1;
        for (int i = 0; i < 16 * nlines; i++) ob.push_back(8'($urandom));
        for (int i = 0; i < nlines; i++) begin
            line = '0;
            for (int b = 0; b < 16; b++) line[8*b +: 8] = ob[16*i + (b + off) % 16];
            rot.push_back(line);
        end
        exp_q.delete();
        for (int n = 0; n < len; n++) begin
            line = '0;
            for (int k = 0; k < 16; k++) line[8*k +: 8] = ob[off + 16*n + k];
            exp_q.push_back(line);
        end

        @(negedge clk);
        start     = 1'b1;
        start_off = 4'(off);
        start_len = LEN_W'(len);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("pre_start_busy", 128'(busy), 128'(0));
        check("pre_start_in_ready", 128'(in_ready), 128'(0));

        li = 0; got = 0; cyc = 0; stall_left = 0; stall_used = 0; done = 0; prev_stall = 0;
        held_data = '0; held_last = 0;
        while (!done) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) check("busy_after_start", 128'(busy), 128'(1));
            if (poke_start && cyc == 2) begin
                start     = 1'b1;
                start_off = 4'($urandom_range(0, 15));
                start_len = LEN_W'($urandom_range(1, 9));
            end
            if (rdy_mode == 2) begin
                if (!stall_used && out_valid) begin
                    stall_used = 1;
                    stall_left = 4;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else out_ready = 1'b1;
            end else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = 1'b1;
            if (li < nlines) begin
                in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = rot[li];
            end else begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data", out_data, held_data);
                check("stall_last", 128'(out_last), 128'(held_last));
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                held_data = out_data;
                held_last = out_last;
                check("stall_in_ready", 128'(in_ready), 128'(0));
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_in) begin
                if (li >= nlines) check("line_overrun", 128'(li), 128'(nlines - 1));
                else li++;
            end
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 128'(got), 128'(len - 1));
                end else begin
                    line = exp_q.pop_front();
                    check("word_data", out_data, line);
                    check("word_last", 128'(out_last), 128'(exp_q.size() == 0));
                    got++;
                    if (exp_q.size() == 0) done = 1;
                end
                if (abort_after != 0 && got == abort_after) break;
            end
            cyc++;
            if (cyc > 2000) begin
                check("xfer_timeout", 128'(got), 128'(len));
                break;
            end
        end
        start = 1'b0;
        if (done) check("lines_consumed", 128'(li), 128'(nlines));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_off = '0; start_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #3;
        check_idle_outputs("reset");
        check("reset_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // off=0, len=2, back-to-back lines and always-ready consumer
        run_xfer(0, 2, 0, 0, 0, 0);
        // off=3, len=1 (two lines stitched into one word)
        run_xfer(3, 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("after_off3_in_ready", 128'(in_ready), 128'(0));
        check("after_off3_busy", 128'(busy), 128'(0));

        // off=15, len=3 with a 4-cycle output stall after the first word
        run_xfer(15, 3, 2, 0, 0, 0);
`ifdef LOAD_LINE_MERGER_STATS_EN
        #1;
        check("stall_cnt", 128'(stall_cnt), 128'(4));
`endif

        // zero-length start is ignored
        @(negedge clk);
        start = 1'b1; start_off = 4'd3; start_len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_busy", 128'(busy), 128'(0));
        check("len0_in_ready", 128'(in_ready), 128'(0));

        // start while busy is ignored
        run_xfer(7, 4, 0, 1, 1, 0);

        // asynchronous reset mid-stream after the first word
        run_xfer(5, 4, 0, 0, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(0, 1, 0, 0, 0, 0);

        // back-to-back random transfers, each started the cycle after the previous last word
        for (int t = 0; t < 12; t++) begin
            run_xfer($urandom_range(0, 15), $urandom_range(1, 6), $urandom_range(0, 1),
                     1'($urandom_range(0, 1)), 0, 0);
        end

        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("final_busy", 128'(busy), 128'(0));
        check("final_in_ready", 128'(in_ready), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
